nested_index_counter: RTL and testbench

Parametrised multi-level modulo counter that walks an N-dimensional index space (e.g. row × column × block) for the matrix encoder datapath. Each level counts modulo its own run-time maximum and carries into the next level. A start/done handshake frames each traversal. It replaces single-level enable/overflow counters wherever nested loop indices are needed, and exposes per-level carries so downstream stages can react to row or block boundaries.

---
 rtl/nested_index_counter.sv | 154 +++++++++++++++
 tb/tb_nested_index_counter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/nested_index_counter.sv
// Multi-level modulo counter walking an N-dimensional index space with a start/done handshake.
// Optional index preload (ld/ld_val) is enabled by defining COUNTER_PRELOAD_EN.
module nested_index_counter #(
  parameter int WORD_LENGTH = 8,
  parameter int LEVELS      = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          start,
  input  logic                          en,
`ifdef COUNTER_PRELOAD_EN
  input  logic                          ld,
  input  logic [LEVELS*WORD_LENGTH-1:0] ld_val,
`endif
  input  logic [LEVELS*WORD_LENGTH-1:0] max,
  output logic [LEVELS*WORD_LENGTH-1:0] out,
  output logic [LEVELS-1:0]             carry,
  output logic                          overflow,
  output logic                          busy,
  output logic                          done
);

  localparam int LW = LEVELS * WORD_LENGTH;
  localparam logic [WORD_LENGTH-1:0] ZERO = {WORD_LENGTH{1'b0}};
  localparam logic [WORD_LENGTH-1:0] ONE  = {{(WORD_LENGTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [LW-1:0]    max_r, idx_r, idx_s;
  logic             busy_r, done_r;
  logic             load_s;
  logic [LW-1:0]    load_val_s;
  logic [LW-1:0]    term_s;
  logic [LEVELS-1:0] at_term_s, inc_s, carry_s;
  logic             chain_s;

`ifdef COUNTER_PRELOAD_EN
  assign load_s     = ld & (state_r == RUN);
  assign load_val_s = ld_val;
`else
  assign load_s     = 1'b0;
  assign load_val_s = {LW{1'b0}};
`endif

  // Terminal detection per level and the ripple carry chain (modulus 0 behaves as 1)
  always_comb begin
    chain_s   = (state_r == RUN) & en & ~load_s;
    term_s    = {LW{1'b0}};
    at_term_s = {LEVELS{1'b0}};
    inc_s     = {LEVELS{1'b0}};
    carry_s   = {LEVELS{1'b0}};
    for (int i = 0; i < LEVELS; i++) begin
      if (max_r[i*WORD_LENGTH +: WORD_LENGTH] == ZERO) begin
        term_s[i*WORD_LENGTH +: WORD_LENGTH] = ZERO;
      end else begin
        term_s[i*WORD_LENGTH +: WORD_LENGTH] = max_r[i*WORD_LENGTH +: WORD_LENGTH] - ONE;
      end
      at_term_s[i] = (idx_r[i*WORD_LENGTH +: WORD_LENGTH] == term_s[i*WORD_LENGTH +: WORD_LENGTH]);
      inc_s[i]     = chain_s;
      chain_s      = chain_s & at_term_s[i];
      carry_s[i]   = chain_s;
    end
  end

  assign carry    = carry_s;
  assign overflow = carry_s[LEVELS-1];

  // Next-state and next-index logic; clr overrides everything else
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    if (clr) begin
      state_s = IDLE;
      idx_s   = {LW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_s = RUN;
            idx_s   = {LW{1'b0}};
          end else begin
            state_s = IDLE;
          end
        end
        RUN: begin
          if (load_s) begin
            // Out-of-range preload fields fall back to 0 so the index stays legal
            for (int i = 0; i < LEVELS; i++) begin
              if (load_val_s[i*WORD_LENGTH +: WORD_LENGTH] < max_r[i*WORD_LENGTH +: WORD_LENGTH]) begin
                idx_s[i*WORD_LENGTH +: WORD_LENGTH] = load_val_s[i*WORD_LENGTH +: WORD_LENGTH];
              end else begin
                idx_s[i*WORD_LENGTH +: WORD_LENGTH] = ZERO;
              end
            end
          end else if (en) begin
            for (int i = 0; i < LEVELS; i++) begin
              if (inc_s[i] && at_term_s[i]) begin
                idx_s[i*WORD_LENGTH +: WORD_LENGTH] = ZERO;
              end else if (inc_s[i]) begin
                idx_s[i*WORD_LENGTH +: WORD_LENGTH] = idx_r[i*WORD_LENGTH +: WORD_LENGTH] + ONE;
              end else begin
                idx_s[i*WORD_LENGTH +: WORD_LENGTH] = idx_r[i*WORD_LENGTH +: WORD_LENGTH];
              end
            end
            if (carry_s[LEVELS-1]) begin
              state_s = DONE;
            end else begin
              state_s = RUN;
            end
          end else begin
            state_s = RUN;
          end
        end
        DONE: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
          idx_s   = {LW{1'b0}};
        end
      endcase
    end
  end

  // State, index, latched modulus and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= {LW{1'b0}};
      max_r   <= {LW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == DONE);
      if (!clr && (state_r == IDLE) && start) begin
        max_r <= max;
      end
    end
  end

  assign out  = idx_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_nested_index_counter.sv
// Randomized bench for nested_index_counter against a linear-step-count reference model.
// Define COUNTER_PRELOAD_EN for both RTL and bench to exercise the preload ports.
module tb_nested_index_counter;

  localparam int W  = 8;
  localparam int L  = 3;
  localparam int LW = L * W;

  logic          clk = 1'b0;
  logic          rst, clr, start, en;
  logic [LW-1:0] max, out;
  logic [L-1:0]  carry;
  logic          overflow, busy, done;
`ifdef COUNTER_PRELOAD_EN
  logic          ld;
  logic [LW-1:0] ld_val;
`endif

  nested_index_counter #(.WORD_LENGTH(W), .LEVELS(L)) dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .en(en),
`ifdef COUNTER_PRELOAD_EN
    .ld(ld), .ld_val(ld_val),
`endif
    .max(max), .out(out), .carry(carry), .overflow(overflow),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase (0 idle, 1 run, 2 done), linear step count within the traversal, latched moduli
  int m_state = 0;
  int m_count = 0;
  int m_mods[L];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int eff(input int i);
    return (m_mods[i] == 0) ? 1 : m_mods[i];
  endfunction

  function automatic int pprod(input int i);
    int p = 1;
    for (int k = 0; k <= i; k++) p *= eff(k);
    return p;
  endfunction

  function automatic logic [LW-1:0] exp_out();
    logic [LW-1:0] v = {LW{1'b0}};
    int div = 1;
    for (int i = 0; i < L; i++) begin
      v[i*W +: W] = W'((m_count / div) % eff(i));
      div *= eff(i);
    end
    return v;
  endfunction

  function automatic logic [LW-1:0] pack3(input int a, input int b, input int c);
    logic [LW-1:0] v;
    v[0 +: W]   = W'(a);
    v[W +: W]   = W'(b);
    v[2*W +: W] = W'(c);
    return v;
  endfunction

  // One clock: check registered outputs, drive inputs, check combinational outputs, advance model
  task automatic cycle(input logic s, input logic e, input logic c, input logic [LW-1:0] mx,
                       input logic l, input logic [LW-1:0] lv);
    logic [L-1:0] ec;
    int stride;
    check_val("out", 64'(out), 64'(exp_out()));
    check_val("busy", 64'(busy), 64'(m_state == 1));
    check_val("done", 64'(done), 64'(m_state == 2));
    start = s; en = e; clr = c; max = mx;
`ifdef COUNTER_PRELOAD_EN
    ld = l; ld_val = lv;
`endif
    #1;
    for (int i = 0; i < L; i++)
      ec[i] = (m_state == 1) && e && !l && (((m_count + 1) % pprod(i)) == 0);
    check_val("carry", 64'(carry), 64'(ec));
    check_val("overflow", 64'(overflow), 64'(ec[L-1]));
    @(posedge clk);
    if (c) begin
      m_state = 0; m_count = 0;
    end else if (m_state == 0) begin
      if (s) begin
        for (int i = 0; i < L; i++) m_mods[i] = int'(mx[i*W +: W]);
        m_count = 0; m_state = 1;
      end
    end else if (m_state == 1) begin
      if (l) begin
        m_count = 0; stride = 1;
        for (int i = 0; i < L; i++) begin
          if (int'(lv[i*W +: W]) < m_mods[i]) m_count += int'(lv[i*W +: W]) * stride;
          stride *= eff(i);
        end
      end else if (e) begin
        m_count++;
        if (m_count == pprod(L-1)) begin
          m_count = 0; m_state = 2;
        end
      end
    end else begin
      m_state = 0;
    end
    @(negedge clk);
  endtask

  // Start a traversal, hold en high, and count steps until done appears
  task automatic run_trav(input logic [LW-1:0] mx, input int exp_steps, input string tag);
    int n = 0;
    cycle(1'b1, 1'b0, 1'b0, mx, 1'b0, {LW{1'b0}});
    while (!done && n < 200) begin
      cycle(1'b0, 1'b1, 1'b0, mx ^ pack3(1, 1, 1), 1'b0, {LW{1'b0}});
      n++;
    end
    check_val(tag, 64'(n), 64'(exp_steps));
    cycle(1'b0, 1'b1, 1'b0, mx, 1'b0, {LW{1'b0}});
  endtask

  initial begin
    for (int i = 0; i < L; i++) m_mods[i] = 0;
    rst = 1'b1; clr = 1'b0; start = 1'b0; en = 1'b0; max = {LW{1'b0}};
`ifdef COUNTER_PRELOAD_EN
    ld = 1'b0; ld_val = {LW{1'b0}};
`endif
    @(negedge clk);
    check_val("rst_out", 64'(out), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_carry", 64'(carry), 64'd0);
    rst = 1'b0;

    // Full traversal, en held high: 2*3*4 steps
    run_trav(pack3(2, 3, 4), 24, "steps_234");
    // Level 1 modulus 0 acts as 1: 2*1*4 steps
    run_trav(pack3(2, 0, 4), 8, "steps_204");

    // en toggling during a traversal
    cycle(1'b1, 1'b0, 1'b0, pack3(2, 3, 4), 1'b0, {LW{1'b0}});
    for (int k = 0; k < 60; k++)
      cycle(1'b0, 1'(k % 2), 1'b0, pack3(4, 4, 4), 1'b0, {LW{1'b0}});

    // Asynchronous reset mid-traversal
    cycle(1'b1, 1'b0, 1'b0, pack3(2, 3, 4), 1'b0, {LW{1'b0}});
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 1'b0, pack3(2, 3, 4), 1'b0, {LW{1'b0}});
    rst = 1'b1;
    #1;
    check_val("arst_out", 64'(out), 64'd0);
    check_val("arst_busy", 64'(busy), 64'd0);
    check_val("arst_done", 64'(done), 64'd0);
    m_state = 0; m_count = 0;
    for (int i = 0; i < L; i++) m_mods[i] = 0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 1'b1, 1'b0, pack3(2, 3, 4), 1'b0, {LW{1'b0}});

    // clr after step 5, then a fresh start
    cycle(1'b1, 1'b0, 1'b0, pack3(2, 3, 4), 1'b0, {LW{1'b0}});
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0, pack3(2, 3, 4), 1'b0, {LW{1'b0}});
    cycle(1'b1, 1'b1, 1'b1, pack3(2, 3, 4), 1'b0, {LW{1'b0}});
    run_trav(pack3(3, 2, 2), 12, "steps_after_clr");

`ifdef COUNTER_PRELOAD_EN
    // Preload in RUN, including an out-of-range field
    cycle(1'b1, 1'b0, 1'b0, pack3(2, 3, 4), 1'b0, {LW{1'b0}});
    cycle(1'b0, 1'b1, 1'b0, pack3(2, 3, 4), 1'b0, {LW{1'b0}});
    cycle(1'b0, 1'b1, 1'b0, pack3(2, 3, 4), 1'b1, pack3(1, 1, 3));
    check_val("ld_out", 64'(out), 64'(pack3(1, 1, 3)));
    cycle(1'b0, 1'b1, 1'b0, pack3(2, 3, 4), 1'b1, pack3(1, 1, 5));
    check_val("ld_clamp", 64'(out), 64'(pack3(1, 1, 0)));
    cycle(1'b0, 1'b0, 1'b1, pack3(2, 3, 4), 1'b0, {LW{1'b0}});
`endif

    // Randomized traffic: start in RUN, en in IDLE/DONE, max changes mid-run, occasional clr
    for (int k = 0; k < 3000; k++) begin
      logic [LW-1:0] mx, lv;
      logic l;
      mx = pack3($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
      lv = pack3($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
`ifdef COUNTER_PRELOAD_EN
      l = ($urandom_range(0, 15) == 0);
`else
      l = 1'b0;
`endif
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 63) == 0), mx, l, lv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
